md_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage. It is the consumer side of the D/X pipeline register.
- Decodes the instruction held in the D/X latch. For any M-extension instruction it stalls the D/X latch and all upstream stages until the result is ready.
- Delivers a 32-bit result to the X-stage result mux for exactly one cycle.
- All state updates on the falling edge of clock, matching the pipeline latches.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_decode.sv | 32 +++
 rtl/md_unit.sv | 145 ++++++++++++++
 tb/tb_md_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared constants and state encoding for the RV32M multiply/divide unit.
// Also used by the hazard unit through md_decode.
package md_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1,
        BUSY = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_decode.sv
// Combinational M-extension decode: recognises RV32M ops and classifies
// them by kind, operand signedness and which product half is returned.
module md_decode
    import md_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_md,
    output logic        is_div,
    output logic        is_rem,
    output logic        sign_a_used,
    output logic        sign_b_used,
    output logic        upper_half
);

    logic [2:0] funct3;
    logic       unused_insn_bits;

    assign funct3           = insn[14:12];
    assign unused_insn_bits = ^{insn[24:15], insn[11:7]};

    assign is_md  = (insn[6:0] == OPC_OP) && (insn[31:25] == F7_MULDIV);
    assign is_div = funct3[2];
    assign is_rem = funct3[2] & funct3[1];

    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 only for MULH, DIV, REM.
    assign sign_a_used = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                         (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign sign_b_used = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                         (funct3 == F3_REM);
    assign upper_half  = ~funct3[2] & (funct3[1:0] != 2'b00);

endmodule

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit in X: stalls D/X while a 32-step
// shift-add multiply or restoring divide runs, then presents one result cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     i_insn,
    input  logic [XLEN-1:0] i_regfile_A,
    input  logic [XLEN-1:0] i_regfile_B,
    input  logic            i_flush,
    output logic            o_is_md,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_result_valid,
    output logic [XLEN-1:0] o_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t state, state_next;

    logic dec_div, dec_rem, sign_a_used, sign_b_used, dec_upper;

    md_decode u_decode (
        .insn        (i_insn),
        .is_md       (o_is_md),
        .is_div      (dec_div),
        .is_rem      (dec_rem),
        .sign_a_used (sign_a_used),
        .sign_b_used (sign_b_used),
        .upper_half  (dec_upper)
    );

    logic [CNT_W-1:0]  cnt;
    logic              div_q, rem_q, upper_q, neg_q;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] acc;

    logic            sign_a, sign_b, start, div_zero, div_ovf, special;
    logic [XLEN-1:0] a_abs, b_abs, special_val;

    assign sign_a   = i_regfile_A[XLEN-1] & sign_a_used;
    assign sign_b   = i_regfile_B[XLEN-1] & sign_b_used;
    assign a_abs    = sign_a ? -i_regfile_A : i_regfile_A;
    assign b_abs    = sign_b ? -i_regfile_B : i_regfile_B;
    assign start    = (state == IDLE) & o_is_md & ~i_flush;
    assign div_zero = (i_regfile_B == '0);
    assign div_ovf  = sign_b_used & (i_regfile_A == INT_MIN) & (i_regfile_B == '1);
    assign special  = dec_div & (div_zero | div_ovf);

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = dec_rem ? i_regfile_A : '1;
        else
            special_val = dec_rem ? '0 : INT_MIN;
    end

    // acc holds {high, multiplier} for multiply and {remainder, quotient} for divide.
    logic [XLEN:0]     mul_sum, div_trial;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_signed;
    logic [XLEN-1:0]   mul_res, div_raw, div_res, final_res;

    assign mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    assign mul_next    = {mul_sum, acc[XLEN-1:1]};
    assign div_trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, b_mag};
    assign div_next    = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                         : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    assign acc_step    = div_q ? div_next : mul_next;
    assign prod_signed = neg_q ? -acc_step : acc_step;
    assign mul_res     = upper_q ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
    assign div_raw     = rem_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    assign div_res     = neg_q ? -div_raw : div_raw;
    assign final_res   = div_q ? div_res : mul_res;

    always_ff @(negedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // DONE never stalls so the D/X latch advances and the op is not re-issued.
    always_comb begin
        state_next     = state;
        o_stall        = 1'b0;
        o_busy         = 1'b0;
        o_result_valid = 1'b0;
        case (state)
            IDLE: begin
                o_stall = o_is_md & ~i_flush;
                if (start) state_next = special ? DONE : BUSY;
            end
            BUSY: begin
                o_busy  = 1'b1;
                o_stall = ~i_flush;
                if (i_flush)              state_next = IDLE;
                else if (cnt == CNT_LAST) state_next = DONE;
            end
            DONE: begin
                o_result_valid = ~i_flush;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            upper_q  <= 1'b0;
            neg_q    <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    div_q   <= dec_div;
                    rem_q   <= dec_rem;
                    upper_q <= dec_upper;
                    neg_q   <= dec_rem ? sign_a : (sign_a ^ sign_b);
                    a_mag   <= a_abs;
                    b_mag   <= b_abs;
                    cnt     <= '0;
                    acc     <= {{XLEN{1'b0}}, (dec_div ? a_abs : b_abs)};
                    if (special) o_result <= special_val;
                end
                BUSY: if (!i_flush) begin
                    acc <= acc_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) o_result <= final_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomised self-checking bench for md_unit against an arithmetic RV32M model.
module tb_md_unit;
    import md_pkg::*;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] ADD_INSN = 32'h0020_81B3;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] insn, reg_a, reg_b;
    logic        flush;
    logic        is_md, stall, busy, result_valid;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    md_unit dut (
        .clock          (clock),
        .reset          (reset),
        .i_insn         (insn),
        .i_regfile_A    (reg_a),
        .i_regfile_B    (reg_b),
        .i_flush        (flush),
        .o_is_md        (is_md),
        .o_stall        (stall),
        .o_busy         (busy),
        .o_result_valid (result_valid),
        .o_result       (result)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mk_insn(input logic [2:0] f3);
        return {F7_MULDIV, 5'd2, 5'd1, f3, 5'd3, OPC_OP};
    endfunction

    // Reference: 64-bit arithmetic on sign/zero-extended operands.
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, q;
        logic [63:0] ua, ub, p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ua; p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Presents one M op as the D/X latch would and holds it until the result cycle.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b);
        int          stalls;
        int          exp_stall;
        bit          got;
        logic [31:0] res, exp;
        exp_q.push_back(ref_md(f3, a, b));
        exp_stall = (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
                    ? 1 : 33;
        @(posedge clock);
        insn   = mk_insn(f3);
        reg_a  = a;
        reg_b  = b;
        stalls = 0;
        got    = 0;
        res    = 'x;
        for (int c = 0; c < 80 && !got; c++) begin
            #1;
            if (result_valid) begin
                got = 1;
                res = result;
                check({tag, "_stall_at_valid"}, {31'b0, stall}, 32'd0);
            end else begin
                if (stall) stalls++;
                @(posedge clock);
            end
        end
        exp = exp_q.pop_front();
        check({tag, "_valid_seen"}, {31'b0, got}, 32'd1);
        check(tag, res, exp);
        check({tag, "_stall_cycles"}, stalls, exp_stall);
    endtask

    initial begin
        logic [31:0] picks[6];
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        int          valids;

        picks = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        reset = 1'b1;
        insn  = NOP_INSN;
        reg_a = '0;
        reg_b = '0;
        flush = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", result, 32'h0);
        check("reset_valid", {31'b0, result_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        @(posedge clock);
        reset = 1'b0;
        insn  = ADD_INSN;
        #1;
        check("add_not_md", {31'b0, is_md}, 32'd0);
        check("add_no_stall", {31'b0, stall}, 32'd0);

        run_op("mul_7x6", F3_MUL, 32'd7, 32'd6);
        run_op("mulh_m1", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_m1", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_m1", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul_m1", F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7);
        run_op("remu_100_7", F3_REMU, 32'd100, 32'd7);
        run_op("divu_by0", F3_DIVU, 32'd5, 32'd0);
        run_op("remu_by0", F3_REMU, 32'd5, 32'd0);
        run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("b2b_3x4", F3_MUL, 32'd3, 32'd4);
        run_op("b2b_5x5", F3_MUL, 32'd5, 32'd5);

        // Flush partway through a multiply.
        @(posedge clock);
        insn  = mk_insn(F3_MUL);
        reg_a = 32'd7;
        reg_b = 32'd6;
        repeat (11) @(posedge clock);
        flush = 1'b1;
        #1;
        check("flush_busy_before", {31'b0, busy}, 32'd1);
        check("flush_stall_drop", {31'b0, stall}, 32'd0);
        @(posedge clock);
        flush = 1'b0;
        insn  = NOP_INSN;
        #1;
        check("flush_idle_after", {31'b0, busy}, 32'd0);
        valids = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            if (result_valid) valids++;
        end
        check("flush_no_valid", valids, 32'd0);

        // Reset partway through a multiply, after a nonzero result is held.
        @(posedge clock);
        insn  = mk_insn(F3_MUL);
        reg_a = 32'd9;
        reg_b = 32'd9;
        repeat (8) @(posedge clock);
        #1;
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        insn  = NOP_INSN;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_valid", {31'b0, result_valid}, 32'd0);
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        @(posedge clock);
        reset = 1'b0;
        run_op("after_reset_mul", F3_MUL, 32'd11, 32'd13);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 15) == 0) rb = 32'h0;
            run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb);
        end

        @(posedge clock);
        insn = NOP_INSN;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
